uart_rx_scheduler: RTL and testbench

- Sequences the UART bit sampler. Synchronises the raw RX pin, qualifies start bits, and generates the sampler's baud_tick pulses aligned to bit centres.
- Checks the stop bit and buffers good bytes in a small FIFO. The pattern-matching engine drains the FIFO through a valid/ready handshake.
- Sits between the rx pin and the sampler on one side, and the matcher on the other.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_fifo.sv | 51 +++++
 rtl/uart_rx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive scheduler.
package uart_pkg;

  localparam int DATA_W        = 8;
  localparam int WAITV_TIMEOUT = 4;

  typedef enum logic [2:0] {
    IDLE,
    VERIFY,
    ARM,
    TICK0,
    DATA,
    STOP,
    WAITV
  } rx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO. A push into a full FIFO is taken only when a pop frees
// a slot in the same cycle; a pop from an empty FIFO is ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [AW:0]             count;
  logic                    do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_scheduler.sv
// UART receive scheduler: start-bit qualification, bit-centre ticks for the
// sampler, stop check and byte FIFO. Optional counters under UART_RX_STATS_EN.
module uart_rx_scheduler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rx_pin,
  input  logic              clear_err,
  output logic              samp_rx,
  output logic              samp_tick,
  input  logic [DATA_W-1:0] samp_data,
  input  logic              samp_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
`ifdef UART_RX_STATS_EN
  ,
  output logic [15:0]       byte_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int WAIT_W = $clog2(WAITV_TIMEOUT);
  localparam logic [CNT_W-1:0]  BIT_TOP   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_TOP  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAITV_TIMEOUT - 1);

  rx_state_t          state;
  logic               sync1, rx_s, rx_d;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WAIT_W-1:0]  wcnt;
  logic               stop_ok;
  logic               push, pop, full, empty, drop, bad_stop;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // Sampler only sees the line once a start bit has been confirmed.
  assign samp_rx = (state == ARM || state == DATA || state == STOP) ? rx_s : 1'b1;
  assign busy    = (state != IDLE);

  // Ticks are registered: raised one cycle ahead, when the counter reaches 1.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      wcnt      <= '0;
      stop_ok   <= 1'b0;
      samp_tick <= 1'b0;
    end else begin
      samp_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && rx_d && !rx_s) begin
            state <= VERIFY;
            cnt   <= HALF_TOP;
          end
        end
        VERIFY: begin
          if (cnt == '0) state <= rx_s ? IDLE : ARM;
          else           cnt   <= cnt - 1'b1;
        end
        ARM: begin
          state     <= TICK0;
          samp_tick <= 1'b1;
        end
        TICK0: begin
          state   <= DATA;
          bit_cnt <= '0;
          cnt     <= BIT_TOP;
        end
        DATA: begin
          if (cnt == CNT_ONE) samp_tick <= 1'b1;
          if (cnt == '0) begin
            cnt <= BIT_TOP;
            if (bit_cnt == BIT_LAST) state   <= STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_ONE) samp_tick <= 1'b1;
          if (cnt == '0) begin
            stop_ok <= rx_s;
            wcnt    <= '0;
            state   <= WAITV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAITV: begin
          if (samp_valid || wcnt == WAIT_LAST) state <= IDLE;
          else                                 wcnt  <= wcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push     = (state == WAITV) && samp_valid && stop_ok;
  assign bad_stop = (state == WAITV) && samp_valid && !stop_ok;
  assign pop      = m_valid && m_ready;
  assign drop     = push && full && !pop;
  assign m_valid  = !empty;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .push    (push),
    .wdata   (samp_data),
    .pop     (pop),
    .rdata   (m_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bad_stop)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (drop)           overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_STATS_EN
  logic byte_ev, err_ev;
  assign byte_ev = push && !drop;
  assign err_ev  = bad_stop || drop;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      err_cnt  <= '0;
    end else if (clear_err) begin
      byte_cnt <= {15'd0, byte_ev};
      err_cnt  <= {15'd0, err_ev};
    end else begin
      if (byte_ev && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
      if (err_ev  && err_cnt  != 16'hFFFF) err_cnt  <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Directed plus random frames against a behavioural sampler and expected-byte model.
module tb_uart_rx_scheduler;

  localparam int C = 16;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, rx_pin = 1'b1, clear_err = 1'b0, m_ready = 1'b0;
  logic       samp_rx, samp_tick, samp_valid, m_valid, busy, frame_err, overrun;
  logic [7:0] samp_data, m_data;
`ifdef UART_RX_STATS_EN
  logic [15:0] byte_cnt, err_cnt;
`endif

  int total = 0, bad = 0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_scheduler #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .rx_pin     (rx_pin),
    .clear_err  (clear_err),
    .samp_rx    (samp_rx),
    .samp_tick  (samp_tick),
    .samp_data  (samp_data),
    .samp_valid (samp_valid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_STATS_EN
    ,
    .byte_cnt   (byte_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // Sampler stand-in: tick 0 aligns, ticks 1..8 take data LSB first, tick 9 is stop.
  int         tidx;
  logic [7:0] shreg;
  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      tidx       <= 0;
      shreg      <= '0;
      samp_valid <= 1'b0;
      samp_data  <= '0;
    end else begin
      samp_valid <= 1'b0;
      if (samp_tick) begin
        if (tidx >= 1 && tidx <= 8) shreg <= {samp_rx, shreg[7:1]};
        if (tidx == 9) begin
          samp_valid <= 1'b1;
          samp_data  <= shreg;
          tidx       <= 0;
        end else begin
          tidx <= tidx + 1;
        end
      end
    end
  end

  // Observers: tick count/spacing, samp_rx low cycles, m_valid cycles, popped bytes.
  int         cyc = 0, last_tick = 0, tick_total = 0, spacing_bad = 0;
  int         rx_low = 0, vcycles = 0, got_n = 0;
  logic [7:0] got [0:255];
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (samp_tick) begin
      tick_total <= tick_total + 1;
      if (tidx != 0 && (cyc - last_tick) != C) spacing_bad <= spacing_bad + 1;
      last_tick <= cyc;
    end
    if (!samp_rx) rx_low <= rx_low + 1;
    if (m_valid) vcycles <= vcycles + 1;
    if (m_valid && m_ready) begin
      got[got_n[7:0]] <= m_data;
      got_n <= got_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_lvl);
    rx_pin = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      step(C);
    end
    rx_pin = stop_lvl;
    step(C);
    rx_pin = 1'b1;
    step(4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      step(1);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_samp_rx"}, samp_rx, 1'b1);
    chk({tag, "_samp_tick"}, samp_tick, 1'b0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_data"}, m_data, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
  endtask

  initial begin
    int t0, g0, v0, r0;
    logic [7:0] b;
    logic sb;
    logic [7:0] exp_q[$];

    step(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    step(5);

    // Single good frame
    enable = 1'b1; m_ready = 1'b1;
    t0 = tick_total; g0 = got_n; v0 = vcycles;
    send(8'hA5, 1'b1);
    wait_idle(); step(3);
    chk("a5_ticks", tick_total - t0, 10);
    chk("a5_count", got_n - g0, 1);
    chk("a5_data", got[g0[7:0]], 8'hA5);
    chk("a5_valid_cycles", vcycles - v0, 1);
    chk("a5_frame_err", frame_err, 1'b0);

    // Short glitch rejected
    t0 = tick_total; r0 = rx_low;
    rx_pin = 1'b0; step(3); rx_pin = 1'b1; step(20);
    chk("glitch_ticks", tick_total - t0, 0);
    chk("glitch_samp_rx", rx_low - r0, 0);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_m_valid", m_valid, 1'b0);

    // Bad stop bit
    t0 = tick_total; g0 = got_n;
    send(8'h3C, 1'b0);
    wait_idle(); step(3);
    chk("3c_frame_err", frame_err, 1'b1);
    chk("3c_no_push", got_n - g0, 0);
    chk("3c_ticks", tick_total - t0, 10);
    pulse_clear(); step(1);
    chk("3c_cleared", frame_err, 1'b0);

    // Overrun with consumer stalled
    m_ready = 1'b0; g0 = got_n;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      wait_idle();
    end
    step(2);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_head_valid", m_valid, 1'b1);
    chk("ovr_head_data", m_data, 8'h01);
    m_ready = 1'b1; step(8);
    chk("ovr_count", got_n - g0, 4);
    for (int i = 0; i < 4; i++) chk("ovr_order", got[8'(g0 + i)], 8'(i + 1));
    chk("ovr_drained", m_valid, 1'b0);

    // Reset mid-frame drops buffered byte and frame
    m_ready = 1'b0;
    send(8'h77, 1'b1);
    wait_idle(); step(2);
    chk("pre_rst_valid", m_valid, 1'b1);
    chk("pre_rst_data", m_data, 8'h77);
    rx_pin = 1'b0; step(C); rx_pin = 1'b1; step(40);
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1; #1;
    chk_reset_vals("midrst");
    step(3); reset = 1'b0; step(5);
    m_ready = 1'b1; g0 = got_n; t0 = tick_total;
    send(8'h81, 1'b1);
    wait_idle(); step(3);
    chk("81_count", got_n - g0, 1);
    chk("81_data", got[g0[7:0]], 8'h81);
    chk("81_ticks", tick_total - t0, 10);

    // enable dropped mid-frame; frame still completes
    g0 = got_n;
    fork
      send(8'h5A, 1'b1);
      begin step(60); enable = 1'b0; end
    join
    wait_idle(); step(3);
    chk("5a_count", got_n - g0, 1);
    chk("5a_data", got[g0[7:0]], 8'h5A);
    t0 = tick_total; g0 = got_n;
    send(8'hC3, 1'b1);
    step(5);
    chk("dis_ticks", tick_total - t0, 0);
    chk("dis_no_byte", got_n - g0, 0);
    chk("dis_busy", busy, 1'b0);

    // Random frames against the expected-byte model
    enable = 1'b1; step(5);
    for (int k = 0; k < 8; k++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      g0 = got_n; t0 = tick_total;
      if (sb) exp_q.push_back(b);
      send(b, sb);
      wait_idle(); step(3);
      chk("rnd_ticks", tick_total - t0, 10);
      chk("rnd_frame_err", frame_err, !sb);
      chk("rnd_count", got_n - g0, sb ? 1 : 0);
      if (sb) chk("rnd_data", got[g0[7:0]], exp_q.pop_front());
      pulse_clear();
    end

    chk("tick_spacing", spacing_bad, 0);
    chk("final_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
